// File: rtl/enc_lcu_rc_pkg.sv
// Shared encoder rate-control definitions: widths, QP limit, FSM encoding
// and the saturating accumulator helper.
package enc_lcu_rc_pkg;

  localparam int QP_W       = 6;
  localparam int BYTES_W    = 16;
  localparam int CNT_W      = 16;
  localparam int ACC_W      = 24;
  localparam int DELTA_W    = 8;
  localparam int ENC_QP_MAX = 51;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CALC   = 3'd3,
    ST_UPDATE = 3'd4
  } rc_state_e;

  // Add a byte count to a frame accumulator, pinning at all-ones on overflow.
  function automatic logic [ACC_W-1:0] sat_acc_add(input logic [ACC_W-1:0] acc,
                                                   input logic [BYTES_W-1:0] inc);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W-BYTES_W+1){1'b0}}, inc};
    if (sum[ACC_W]) begin
      return {ACC_W{1'b1}};
    end else begin
      return sum[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/enc_rc_qp_clamp.sv
// Signed sum of base QP and LCU delta, clamped into 0..QP_MAX.
module enc_rc_qp_clamp
  import enc_lcu_rc_pkg::*;
#(
  parameter int QP_MAX = ENC_QP_MAX
) (
  input  logic        [QP_W-1:0]    base_qp_i,
  input  logic signed [DELTA_W-1:0] delta_i,
  output logic        [QP_W-1:0]    qp_o
);

  localparam int SUM_W = QP_W + 3;
  localparam logic signed [SUM_W-1:0] QP_MAX_S = SUM_W'(QP_MAX);
  localparam logic [QP_W-1:0]         QP_MAX_Q = QP_W'(QP_MAX);

  logic signed [SUM_W-1:0] sum_s;

  // Widen both operands so a negative delta on a small base cannot wrap.
  always_comb begin
    sum_s = $signed({{(SUM_W-QP_W){1'b0}}, base_qp_i}) + SUM_W'(delta_i);
    if (sum_s[SUM_W-1]) begin
      qp_o = {QP_W{1'b0}};
    end else if (sum_s > QP_MAX_S) begin
      qp_o = QP_MAX_Q;
    end else begin
      qp_o = sum_s[QP_W-1:0];
    end
  end

endmodule

// File: rtl/enc_lcu_rc.sv
// LCU-level rate control: tracks actual vs budgeted bytes over a frame and
// nudges the QP of the next LCU by a bounded offset from the frame QP.
module enc_lcu_rc
  import enc_lcu_rc_pkg::*;
#(
  parameter int QP_DELTA_MAX = 4,
  parameter int QP_MAX       = ENC_QP_MAX
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sys_start_i,
  input  logic               rc_en_i,
  input  logic [QP_W-1:0]    frame_qp_i,
  input  logic [CNT_W-1:0]   lcu_num_i,
  input  logic [BYTES_W-1:0] target_bytes_i,
  input  logic               enc_done_i,
  input  logic [BYTES_W-1:0] rc_actual_bitnum_i,
  output logic [QP_W-1:0]    rc_qp_o,
  output logic               rc_qp_val_o,
  output logic [ACC_W-1:0]   frame_bytes_o,
  output logic               frame_done_o,
  output logic               protocol_err_o
);

  localparam logic signed [DELTA_W-1:0] DELTA_MAX_S = DELTA_W'(QP_DELTA_MAX);
  localparam logic signed [DELTA_W-1:0] DELTA_MIN_S = -DELTA_MAX_S;

  rc_state_e                  state_q, state_d;
  logic                       rc_en_q, rc_en_d;
  logic        [QP_W-1:0]     frame_qp_q, frame_qp_d;
  logic        [CNT_W-1:0]    lcu_num_q, lcu_num_d;
  logic        [BYTES_W-1:0]  target_q, target_d;
  logic        [CNT_W-1:0]    lcu_cnt_q, lcu_cnt_d;
  logic        [ACC_W-1:0]    act_acc_q, act_acc_d;
  logic        [ACC_W-1:0]    tgt_acc_q, tgt_acc_d;
  logic signed [DELTA_W-1:0]  qp_delta_q, qp_delta_d;
  logic        [QP_W-1:0]     rc_qp_q, rc_qp_d;
  logic                       rc_qp_val_q, rc_qp_val_d;
  logic        [ACC_W-1:0]    frame_bytes_q, frame_bytes_d;
  logic                       frame_done_q, frame_done_d;
  logic                       err_q, err_d;

  logic signed [ACC_W:0]      over_s;
  logic signed [ACC_W:0]      tgt_s;
  logic signed [DELTA_W-1:0]  delta_next_s;
  logic        [QP_W-1:0]     clamp_qp_s;

  enc_rc_qp_clamp #(.QP_MAX(QP_MAX)) u_qp_clamp (
    .base_qp_i (frame_qp_q),
    .delta_i   (qp_delta_q),
    .qp_o      (clamp_qp_s)
  );

  // Overrun/underrun decision: one QP step per LCU, bounded to +/-QP_DELTA_MAX.
  always_comb begin
    over_s = $signed({1'b0, act_acc_q}) - $signed({1'b0, tgt_acc_q});
    tgt_s  = $signed({1'b0, {(ACC_W-BYTES_W){1'b0}}, target_q});
    if (!rc_en_q) begin
      delta_next_s = qp_delta_q;
    end else if ((over_s > tgt_s) && (qp_delta_q < DELTA_MAX_S)) begin
      delta_next_s = qp_delta_q + DELTA_W'(1);
    end else if ((over_s < -tgt_s) && (qp_delta_q > DELTA_MIN_S)) begin
      delta_next_s = qp_delta_q - DELTA_W'(1);
    end else begin
      delta_next_s = qp_delta_q;
    end
  end

  // Next-state logic; a frame start overrides whatever the FSM is doing.
  always_comb begin
    state_d       = state_q;
    rc_en_d       = rc_en_q;
    frame_qp_d    = frame_qp_q;
    lcu_num_d     = lcu_num_q;
    target_d      = target_q;
    lcu_cnt_d     = lcu_cnt_q;
    act_acc_d     = act_acc_q;
    tgt_acc_d     = tgt_acc_q;
    qp_delta_d    = qp_delta_q;
    rc_qp_d       = rc_qp_q;
    frame_bytes_d = frame_bytes_q;
    err_d         = err_q;
    rc_qp_val_d   = 1'b0;
    frame_done_d  = 1'b0;
    if (sys_start_i) begin
      state_d       = ST_WAIT;
      rc_en_d       = rc_en_i;
      frame_qp_d    = frame_qp_i;
      lcu_num_d     = lcu_num_i;
      target_d      = target_bytes_i;
      lcu_cnt_d     = {CNT_W{1'b0}};
      act_acc_d     = {ACC_W{1'b0}};
      tgt_acc_d     = {ACC_W{1'b0}};
      qp_delta_d    = {DELTA_W{1'b0}};
      rc_qp_d       = frame_qp_i;
      frame_bytes_d = {ACC_W{1'b0}};
      err_d         = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT: begin
          if (enc_done_i) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_SAMPLE: begin
          act_acc_d = sat_acc_add(act_acc_q, rc_actual_bitnum_i);
          tgt_acc_d = sat_acc_add(tgt_acc_q, target_q);
          lcu_cnt_d = lcu_cnt_q + CNT_W'(1);
          err_d     = err_q | enc_done_i;
          state_d   = ST_CALC;
        end
        ST_CALC: begin
          qp_delta_d = delta_next_s;
          err_d      = err_q | enc_done_i;
          state_d    = ST_UPDATE;
        end
        ST_UPDATE: begin
          rc_qp_d       = clamp_qp_s;
          rc_qp_val_d   = 1'b1;
          frame_bytes_d = act_acc_q;
          err_d         = err_q | enc_done_i;
          if (lcu_cnt_q == lcu_num_q) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d      = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      rc_en_q       <= 1'b0;
      frame_qp_q    <= {QP_W{1'b0}};
      lcu_num_q     <= {CNT_W{1'b0}};
      target_q      <= {BYTES_W{1'b0}};
      lcu_cnt_q     <= {CNT_W{1'b0}};
      act_acc_q     <= {ACC_W{1'b0}};
      tgt_acc_q     <= {ACC_W{1'b0}};
      qp_delta_q    <= {DELTA_W{1'b0}};
      rc_qp_q       <= {QP_W{1'b0}};
      rc_qp_val_q   <= 1'b0;
      frame_bytes_q <= {ACC_W{1'b0}};
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rc_en_q       <= rc_en_d;
      frame_qp_q    <= frame_qp_d;
      lcu_num_q     <= lcu_num_d;
      target_q      <= target_d;
      lcu_cnt_q     <= lcu_cnt_d;
      act_acc_q     <= act_acc_d;
      tgt_acc_q     <= tgt_acc_d;
      qp_delta_q    <= qp_delta_d;
      rc_qp_q       <= rc_qp_d;
      rc_qp_val_q   <= rc_qp_val_d;
      frame_bytes_q <= frame_bytes_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign rc_qp_o        = rc_qp_q;
  assign rc_qp_val_o    = rc_qp_val_q;
  assign frame_bytes_o  = frame_bytes_q;
  assign frame_done_o   = frame_done_q;
  assign protocol_err_o = err_q;

endmodule

// File: doc/enc_lcu_rc.md
ENC_LCU_RC -- requirements
Module: enc_lcu_rc

Interface
REQ-001 SHALL have parameter QP_DELTA_MAX, default 4, meaning maximum absolute LCU QP offset from frame QP.
REQ-002 SHALL have parameter QP_MAX, default 51, meaning upper QP clamp.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sys_start_i  input  1  frame start pulse.
REQ-006 SHALL have port rc_en_i  input  1  rate control enable, sampled at sys_start_i.
REQ-007 SHALL have port frame_qp_i  input  6  frame base QP, sampled at sys_start_i.
REQ-008 SHALL have port lcu_num_i  input  16  LCUs per frame, sampled at sys_start_i, 0 illegal.
REQ-009 SHALL have port target_bytes_i  input  16  per-LCU byte budget, sampled at sys_start_i.
REQ-010 SHALL have port enc_done_i  input  1  LCU-done pulse, same signal that advances the encoder data pipeline.
REQ-011 SHALL have port rc_actual_bitnum_i  input  16  registered per-LCU byte count, valid from the cycle after enc_done_i.
REQ-012 SHALL have port rc_qp_o  output  6  QP for the next LCU, consumed as rc_qp_i by the data pipeline.
REQ-013 SHALL have port rc_qp_val_o  output  1  one-cycle pulse, rc_qp_o updated.
REQ-014 SHALL have port frame_bytes_o  output  24  accumulated actual bytes of the current frame.
REQ-015 SHALL have port frame_done_o  output  1  one-cycle pulse after the lcu_num_i-th update.
REQ-016 SHALL have port protocol_err_o  output  1  sticky, enc_done_i seen while busy.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, SAMPLE, CALC, UPDATE: IDLE->WAIT on sys_start_i; WAIT->SAMPLE on enc_done_i; SAMPLE->CALC->UPDATE unconditional; UPDATE->WAIT, or ->IDLE when lcu_cnt == lcu_num_i.
REQ-018 sys_start_i SHALL be accepted in any state, clear lcu_cnt, act_acc, tgt_acc, qp_delta and protocol_err_o, load the frame parameters, set rc_qp_o = frame_qp_i next cycle, and enter WAIT; it SHALL take priority over a simultaneous enc_done_i.
REQ-019 SAMPLE SHALL add rc_actual_bitnum_i to act_acc (24-bit, saturating at 2^24-1), add target_bytes_i to tgt_acc (24-bit, saturating), and increment lcu_cnt.
REQ-020 CALC SHALL form signed 25-bit over = act_acc - tgt_acc.
REQ-020a CALC SHALL increment qp_delta when over > target_bytes_i.
REQ-020b CALC SHALL decrement qp_delta when over < -target_bytes_i.
REQ-020c CALC SHALL otherwise hold qp_delta.
REQ-020d qp_delta SHALL saturate at +/-QP_DELTA_MAX.
REQ-021 UPDATE SHALL register rc_qp_o = clamp(frame_qp + qp_delta, 0, QP_MAX), assert rc_qp_val_o for one cycle, and update frame_bytes_o = act_acc.
REQ-022 Latency SHALL be: enc_done_i in cycle T gives rc_qp_o/rc_qp_val_o valid in cycle T+4.
REQ-023 When rc_en_i was 0 at frame start, qp_delta SHALL stay 0, so rc_qp_o = frame_qp; accumulation and pulses SHALL be unchanged.
REQ-024 enc_done_i in SAMPLE, CALC or UPDATE SHALL be ignored and SHALL set protocol_err_o; enc_done_i in IDLE SHALL be ignored without error.
REQ-025 frame_done_o SHALL pulse in the cycle after the UPDATE that makes lcu_cnt == lcu_num_i.

Reset
REQ-026 On rstn low: state = IDLE; rc_qp_o, frame_bytes_o and all accumulators 0; lcu_cnt 0; qp_delta 0; all pulses 0; protocol_err_o 0.
REQ-027 Reset mid-frame SHALL abandon the frame; the block SHALL resume only on the next sys_start_i.

Structure
REQ-028 The FSM state encodings, QP_MAX and widths (QP 6, bytes 16, accumulators 24) SHALL live in the shared encoder defines package.
REQ-029 A single sub-module enc_rc_qp_clamp (signed add of base QP and delta, clamp 0..QP_MAX) SHALL be used; everything else SHALL be flat.

Verification
REQ-030 Reset, then sys_start_i with frame_qp 30, rc_en 1, target 100, lcu_num 4; four enc_done_i with bitnum 100 each -> rc_qp_o 30 every update, frame_bytes_o 400, frame_done_o once.
REQ-031 Same setup, bitnum 300 per LCU -> rc_qp_o 31, 32, 33, 34; with lcu_num 8 -> saturates at 34.
REQ-032 frame_qp 50, bitnum 400 per LCU -> rc_qp_o clamps at 51; frame_qp 1, bitnum 0 -> rc_qp_o clamps at 0.
REQ-033 rc_en 0, bitnum 500 -> rc_qp_o stays frame_qp, frame_bytes_o still accumulates.
REQ-034 enc_done_i two cycles after a previous one -> second pulse ignored, protocol_err_o 1, lcu_cnt +1 only.
REQ-035 sys_start_i coincident with enc_done_i mid-frame -> counters cleared, state WAIT, no rc_qp_val_o; rstn low in CALC -> all outputs 0, IDLE.
